// File: rtl/tazz_pkg.sv
// Shared definitions for the ROM download sequencer:
// region indices, FSM states and the FIFO entry layout.
package tazz_pkg;

    localparam logic [1:0] REG_CPU  = 2'd0;
    localparam logic [1:0] REG_SND  = 2'd1;
    localparam logic [1:0] REG_GFX  = 2'd2;
    localparam logic [1:0] REG_PROM = 2'd3;

    localparam int ENTRY_W = 26;

    typedef enum logic [1:0] {
        ST_IDLE_RUN,
        ST_LOAD,
        ST_DRAIN,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic [1:0]  region;
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    function automatic logic [3:0] region_onehot(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is legal
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + AW'(1);
            if (pop_i)  rptr_q <= rptr_q + AW'(1);
            if (push_i && !pop_i)
                cnt_q <= cnt_q + (AW+1)'(1);
            else if (!push_i && pop_i)
                cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/rom_dl_sequencer.sv
// Routes HPS download bytes into four ROM regions through a FIFO
// and sequences the game core reset around the download.
module rom_dl_sequencer
    import tazz_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] CPU_END     = 16'h6000,
    parameter logic [15:0] SND_END     = 16'h7000,
    parameter logic [15:0] GFX_END     = 16'h8000,
    parameter logic [15:0] PROM_END    = 16'h8020,
    parameter int          HOLD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        reset_req,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [15:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        mem_ce,
    output logic [3:0]  rom_we,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        core_reset,
    output logic        dl_done,
    output logic        dl_err
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          core_reset_q;
    logic          dl_done_q;
    logic          dl_err_q;
    logic          loaded_q;
    logic [3:0]    rom_we_q;
    logic [15:0]   rom_addr_q;
    logic [7:0]    rom_data_q;

    entry_t wr_e;
    entry_t rd_e;
    logic   in_map;
    logic   push_req;
    logic   push;
    logic   pop;
    logic   full;
    logic   empty;
    logic   err_set;

    always_comb begin
        wr_e.region = REG_CPU;
        wr_e.addr   = dl_addr;
        wr_e.data   = dl_data;
        in_map      = 1'b1;
        if (dl_addr < CPU_END) begin
            wr_e.region = REG_CPU;
        end else if (dl_addr < SND_END) begin
            wr_e.region = REG_SND;
            wr_e.addr   = dl_addr - CPU_END;
        end else if (dl_addr < GFX_END) begin
            wr_e.region = REG_GFX;
            wr_e.addr   = dl_addr - SND_END;
        end else if (dl_addr < PROM_END) begin
            wr_e.region = REG_PROM;
            wr_e.addr   = dl_addr - GFX_END;
        end else begin
            in_map      = 1'b0;
        end
    end

    // A full FIFO still takes a byte when the same cycle drains one.
    assign pop      = !empty && mem_ce;
    assign push_req = (state_q == ST_LOAD) && dl_wr;
    assign push     = push_req && in_map && (!full || pop);
    assign err_set  = push_req && (!in_map || (full && !pop));

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_e),
        .rdata_o (rd_e),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            dl_done_q    <= 1'b0;
            dl_err_q     <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            dl_done_q <= 1'b0;
            if (err_set) dl_err_q <= 1'b1;
            case (state_q)
                ST_IDLE_RUN: begin
                    if (dl_active) begin
                        state_q      <= ST_LOAD;
                        loaded_q     <= 1'b1;
                        dl_err_q     <= 1'b0;
                        core_reset_q <= 1'b1;
                    end else if (reset_req) begin
                        state_q      <= ST_HOLD;
                        cnt_q        <= '0;
                        core_reset_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!dl_active) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (dl_active) begin
                        state_q <= ST_LOAD;
                    end else if (empty && !pop) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (dl_active) begin
                        state_q  <= ST_LOAD;
                        loaded_q <= 1'b1;
                        dl_err_q <= 1'b0;
                    end else if (reset_req) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= ST_IDLE_RUN;
                        cnt_q        <= '0;
                        core_reset_q <= 1'b0;
                        dl_done_q    <= loaded_q;
                        loaded_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            rom_we_q   <= '0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
        end else begin
            rom_we_q <= '0;
            if (pop) begin
                rom_we_q   <= region_onehot(rd_e.region);
                rom_addr_q <= rd_e.addr;
                rom_data_q <= rd_e.data;
            end
        end
    end

    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign core_reset = core_reset_q;
    assign dl_done    = dl_done_q;
    assign dl_err     = dl_err_q;

endmodule
